// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared FSM state, captured-op encoding and word size for mips_mem_responder
package mem_resp_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   typedef enum logic [1:0] {NONE, RD, WR, BAD} op_t;
   localparam int WORD_BYTES = 4;
endpackage

// File: rtl/mem_word_ram.sv
// mem_word_ram: word-organised RAM with synchronous write, combinational read and no reset
module mem_word_ram #(
  parameter int    DEPTH_WORDS = 256,
  parameter string INIT_FILE   = "",
  parameter int    AW          = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/mips_mem_responder.sv
// mips_mem_responder: memory slave with configurable wait states and one-cycle ready strobe
//   clk       in  clock
//   rst       in  asynchronous active-low reset
//   mem_read  in  read request
//   mem_write in  write request
//   addr      in  byte address
//   wdata     in  write data
//   rdata     out read data, valid with mem_ready
//   mem_ready out one-cycle response strobe
//   mem_err   out error flag, valid with mem_ready
//   busy      out high from the cycle after accept through the response cycle
module mips_mem_responder
   import mem_resp_pkg::*;
#(
   parameter int    DEPTH_WORDS = 256,
   parameter int    WAIT_CYCLES = 2,
   parameter string INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        mem_ready,
   output logic        mem_err,
   output logic        busy
);
   localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
   localparam int BW = $clog2(WORD_BYTES);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
   state_t        state, state_nx;
   op_t           op_q;
   logic [31:0]   addr_q, wdata_q, ram_rdata;
   logic [CW-1:0] cnt;
   logic          accept, err, we;
   assign accept = (state == IDLE) && (mem_read || mem_write);
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         op_q    <= NONE;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state <= state_nx;
         cnt   <= accept ? CNT_LOAD : (state == WAIT && cnt != '0) ? cnt - 1'b1 : cnt;
         if (accept) begin
            op_q    <= (mem_read && mem_write) ? BAD : mem_read ? RD : WR;
            addr_q  <= addr;
            wdata_q <= wdata;
         end
      end
   // full 30-bit index compare so high address bits can never alias into the array
   assign err = (op_q == BAD) || (addr_q[BW-1:0] != '0) || (addr_q[31:BW] >= (32-BW)'(DEPTH_WORDS));
   always_comb begin
      state_nx  = IDLE;
      mem_ready = 1'b0;
      state_nx  = (state == IDLE) ? (accept ? (WAIT_CYCLES > 0 ? WAIT : RESP) : IDLE)
                : (state == WAIT) ? (cnt == '0 ? RESP : WAIT)
                : IDLE;
      mem_ready = (state == RESP);
   end
   assign busy    = (state != IDLE);
   assign mem_err = mem_ready && err;
   assign rdata   = (mem_ready && !err && op_q == RD) ? ram_rdata : '0;
   assign we      = mem_ready && !err && op_q == WR;
   mem_word_ram #(.DEPTH_WORDS(DEPTH_WORDS), .INIT_FILE(INIT_FILE), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (we),
      .addr  (addr_q[AW+BW-1:BW]),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );
endmodule
